serial_adder_ctrl: RTL
======================

# serial_adder_ctrl

Bit-serial multi-bit adder: a controller that sequences a single one-bit full adder over WIDTH cycles. It adds two WIDTH-bit operands plus a carry-in, one bit per clock, LSB first. It trades latency for area, and sits wherever a wide ripple adder is too costly and a start/done handshake is acceptable.

## Interface
- WIDTH, 8: operand and result width in bits; legal values are 1 or more.
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, synchronous, active-low.
- start  input  1  request to begin an addition; sampled only while busy=0.
- a  input  WIDTH  operand A; latched when start is accepted.
- b  input  WIDTH  operand B; latched when start is accepted.
- cin  input  1  carry-in; latched when start is accepted.
- busy  output  1  high while an addition is in progress.
- done  output  1  one-cycle pulse when sum and cout become valid.
- sum  output  WIDTH  result; holds its value until the next completion or reset.
- cout  output  1  carry-out of the MSB; holds alongside sum.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 latches a, b and cin into internal shift registers and the carry flop, clears the bit counter, and moves to RUN.
  - start=0 stays in IDLE.
- RUN, each cycle:
  - Full adder inputs: a_sh[0], b_sh[0], carry_q.
  - The adder's sum bit shifts into the MSB of the result shift register, which shifts right.
  - a_sh and b_sh shift right; carry_q takes the full adder's carry; the counter increments.
  - When the counter reaches WIDTH-1, the final bit is processed and the FSM moves to DONE.
- DONE:
  - sum is loaded from the result shift register and cout from the final carry, registered on the RUN→DONE edge.
  - done=1 for this single cycle.
  - start=1 in DONE is accepted exactly as in IDLE (back-to-back); otherwise the FSM returns to IDLE.
- busy=1 in RUN only; busy=0 in IDLE and DONE.
- start while busy=1 is ignored. It is not queued and does not disturb the operation in flight.
- Operands may change freely after acceptance; only latched values are used.
- Arithmetic: {cout,sum} = a + b + cin, computed modulo 2^(WIDTH+1), with no truncation of the carry.
- The counter is $clog2(WIDTH+1) bits wide. WIDTH=1 is legal: RUN lasts one cycle.
- Reset, including mid-RUN: the FSM goes to IDLE and the operation is aborted with no done pulse. busy=0, done=0, sum=0, cout=0, and all shift registers, carry and counter are cleared.

## Timing
- Start is accepted on clock edge k. RUN occupies the cycles after edges k through k+WIDTH-1, processing bit i in the cycle after edge k+i.
- done is high in the cycle after edge k+WIDTH. Latency from accepting start to done is WIDTH+1 cycles.
- busy rises after edge k and falls after edge k+WIDTH, coincident with done rising.
- Back-to-back: start sampled high on the edge that leaves DONE gives a new done exactly WIDTH+1 cycles later. Peak throughput is one result per WIDTH+1 cycles.
- sum and cout change only on entry to DONE or on reset. They are glitch-free registered outputs.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package serial_add_pkg holds:
  - the state typedef (IDLE, RUN, DONE);
  - the default WIDTH constant;
  - a function computing the counter width.
- One sub-module: the existing full_adder_struct, built from two half_adder instances, instantiated exactly once as the per-bit datapath.
- The controller contains only the FSM, counter, shift registers and carry flop. No other arithmetic.

## Test plan (WIDTH=8)
- Reset: hold rst_n=0 for 2 cycles with start=1 → busy=0, done=0, sum=0x00, cout=0 throughout and after release with start=0.
- Basic add: a=0x5A, b=0x3C, cin=0, start pulse → busy for 8 cycles, done in cycle 9, sum=0x96, cout=0. Changing a and b on the cycle after start has no effect.
- Carry chain: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1. Then a=0xFF, b=0xFF, cin=1 → sum=0xFF, cout=1.
- Start while busy: start a=0x10, b=0x20, then pulse start with a=0xAA, b=0x55 at RUN cycle 3 → a single done, sum=0x30, cout=0; no second done follows.
- Back-to-back: hold start=1 with a=0x01, b=0x01, then a=0x80, b=0x80 presented in the DONE cycle → first done sum=0x02; second done exactly 9 cycles later with sum=0x00, cout=1.
- Reset mid-run: assert rst_n=0 at RUN cycle 4 → next cycle busy=0, sum=0, no done. A fresh start with a=0x0F, b=0xF0, cin=1 gives sum=0x00, cout=1.

Source files
------------

// File: rtl/serial_add_pkg.sv
// Shared types and sizing helpers for the bit-serial adder controller.
// Holds the FSM state encoding, the default operand width and the counter sizing.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEFAULT_WIDTH = 8;

    // Counter must hold 0..WIDTH-1 and still be at least one bit wide for WIDTH=1.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/full_adder_struct.sv
// Structural one-bit full adder made of two half adders; the per-bit datapath
// shared by every bit position of the serial adder.
module full_adder_struct (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s0;
    logic c0;
    logic c1;

    half_adder u_ha0 (
        .a     (a),
        .b     (b),
        .sum   (s0),
        .carry (c0)
    );

    half_adder u_ha1 (
        .a     (s0),
        .b     (cin),
        .sum   (sum),
        .carry (c1)
    );

    // Both half-adder carries can never be high together, so OR is exact.
    assign cout = c0 | c1;

endmodule

// File: rtl/half_adder.sv
// One-bit half adder; building block of full_adder_struct.
module half_adder (
    input  logic a,
    input  logic b,
    output logic sum,
    output logic carry
);

    assign sum   = a ^ b;
    assign carry = a & b;

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial WIDTH-bit adder: sequences one full adder over WIDTH cycles, LSB first,
// with a start/busy/done handshake and registered sum/cout that hold between results.
module serial_adder_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int               CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_t           state_reg;
    state_t           state_next;
    logic [WIDTH-1:0] a_sh_reg;
    logic [WIDTH-1:0] a_sh_next;
    logic [WIDTH-1:0] b_sh_reg;
    logic [WIDTH-1:0] b_sh_next;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] res_next;
    logic [WIDTH-1:0] res_shift;
    logic [WIDTH-1:0] sum_reg;
    logic [WIDTH-1:0] sum_next;
    logic             carry_reg;
    logic             carry_next;
    logic             cout_reg;
    logic             cout_next;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;
    logic             load;
    logic             fa_sum;
    logic             fa_cout;
    logic             res_lsb_unused;

    full_adder_struct u_fa (
        .a    (a_sh_reg[0]),
        .b    (b_sh_reg[0]),
        .cin  (carry_reg),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // Result register shifts right with the new sum bit entering at the MSB.
    generate
        for (genvar gi = 0; gi < WIDTH - 1; gi++) begin : g_res_shift
            assign res_shift[gi] = res_reg[gi+1];
        end
    endgenerate
    assign res_shift[WIDTH-1] = fa_sum;

    // The oldest bit falls off the end of the shift and never reaches sum.
    assign res_lsb_unused = res_reg[0];

    always_comb begin
        state_next = state_reg;
        a_sh_next  = a_sh_reg;
        b_sh_next  = b_sh_reg;
        res_next   = res_reg;
        sum_next   = sum_reg;
        carry_next = carry_reg;
        cout_next  = cout_reg;
        cnt_next   = cnt_reg;
        load       = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                a_sh_next  = a_sh_reg >> 1;
                b_sh_next  = b_sh_reg >> 1;
                res_next   = res_shift;
                carry_next = fa_cout;
                cnt_next   = cnt_reg + 1'b1;
                if (cnt_reg == CNT_LAST) begin
                    state_next = DONE;
                    sum_next   = res_shift;
                    cout_next  = fa_cout;
                end
            end
            DONE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        if (load) begin
            a_sh_next  = a;
            b_sh_next  = b;
            res_next   = '0;
            carry_next = cin;
            cnt_next   = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            a_sh_reg  <= '0;
            b_sh_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            a_sh_reg  <= a_sh_next;
            b_sh_reg  <= b_sh_next;
            res_reg   <= res_next;
            sum_reg   <= sum_next;
            carry_reg <= carry_next;
            cout_reg  <= cout_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Status flags decode straight from the state register, so they are glitch-free.
    assign busy = (state_reg == RUN);
    assign done = (state_reg == DONE);
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule
